// File: rtl/freq_meter.sv
// freq_meter
//   Counts rising edges of a slow asynchronous input (sig_in) over a fixed gate
//   window of GATE_CYCLES clk_50MHz cycles and publishes each result with a
//   one-cycle strobe. With the default 1 s window, freq_count reads in Hz.
//
// Optional feature macro: FREQ_METER_PERIOD_EN
//   defined   : edge-to-edge period measurement (period_cycles / period_valid)
//   undefined : period_cycles and period_valid are tied to 0
//
// Parameters
//   GATE_CYCLES  gate window length in clk_50MHz cycles (>= 2)
//   CNT_W        width of the edge counter and freq_count
//   PER_W        width of period_cycles
//
// Ports
//   clk_50MHz      in   system clock
//   reset_n        in   asynchronous active-low reset
//   en             in   measurement enable (synchronous)
//   sig_in         in   signal under measurement (asynchronous)
//   freq_count     out  edges counted in the last completed window
//   freq_valid     out  one-cycle strobe, freq_count/overflow/no_signal new
//   overflow       out  edge count saturated during the last window
//   no_signal      out  last window contained zero edges
//   period_cycles  out  clocks between the last two detected edges
//   period_valid   out  one-cycle strobe on each period_cycles update
//
// State table
//   state   | meaning
//   IDLE    | counters held at 0, waiting for en
//   MEASURE | gate window running, edges being counted

module freq_meter #(
  parameter int GATE_CYCLES = 50000000,
  parameter int CNT_W       = 26,
  parameter int PER_W       = 26
) (
  input  logic             clk_50MHz,
  input  logic             reset_n,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq_count,
  output logic             freq_valid,
  output logic             overflow,
  output logic             no_signal,
  output logic [PER_W-1:0] period_cycles,
  output logic             period_valid
);

  localparam int               GATE_W    = $clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic s1, s2, s3;
  logic edge_det;

  logic [GATE_W-1:0] gate_cnt, gate_nxt;
  logic [CNT_W-1:0]  edge_cnt, edge_nxt;
  logic              sticky, sticky_nxt;
  logic              publish;

  logic              gate_end;
  logic              cnt_at_max;
  logic              edge_sat;
  logic [CNT_W-1:0]  cnt_final;

  // Two flops resolve metastability; s3 delays s2 for rising-edge detection.
  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign edge_det = s2 & ~s3;

  assign gate_end   = (state == MEASURE) && (gate_cnt == GATE_LAST);
  assign cnt_at_max = (edge_cnt == CNT_MAX);
  assign edge_sat   = edge_det && cnt_at_max;
  // Count including an edge landing in this cycle, saturating at CNT_MAX.
  assign cnt_final  = (edge_det && !cnt_at_max) ? edge_cnt + 1'b1 : edge_cnt;

  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      gate_cnt <= '0;
      edge_cnt <= '0;
      sticky   <= 1'b0;
    end else begin
      state    <= state_nxt;
      gate_cnt <= gate_nxt;
      edge_cnt <= edge_nxt;
      sticky   <= sticky_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    gate_nxt   = gate_cnt;
    edge_nxt   = edge_cnt;
    sticky_nxt = sticky;
    publish    = 1'b0;
    case (state)
      IDLE: begin
        gate_nxt   = '0;
        edge_nxt   = '0;
        sticky_nxt = 1'b0;
        if (en) state_nxt = MEASURE;
      end
      MEASURE: begin
        if (gate_end) begin
          // Window completes even if en falls in this cycle; the next
          // window starts with no dead cycle.
          publish    = 1'b1;
          gate_nxt   = '0;
          edge_nxt   = '0;
          sticky_nxt = 1'b0;
          if (!en) state_nxt = IDLE;
        end else if (!en) begin
          state_nxt  = IDLE;
          gate_nxt   = '0;
          edge_nxt   = '0;
          sticky_nxt = 1'b0;
        end else begin
          gate_nxt   = gate_cnt + 1'b1;
          edge_nxt   = cnt_final;
          sticky_nxt = sticky | edge_sat;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      freq_count <= '0;
      freq_valid <= 1'b0;
      overflow   <= 1'b0;
      no_signal  <= 1'b0;
    end else begin
      freq_valid <= publish;
      if (publish) begin
        freq_count <= cnt_final;
        overflow   <= sticky | edge_sat;
        no_signal  <= (cnt_final == '0);
      end
    end
  end

`ifdef FREQ_METER_PERIOD_EN
  localparam logic [PER_W-1:0] PER_MAX = '1;

  logic [PER_W-1:0] per_cnt;
  logic             first_seen;
  logic             meas_edge;

  assign meas_edge = (state == MEASURE) && en && edge_det;

  // per_cnt restarts at 1 on an edge so that, at the next edge, it holds
  // the number of clocks between the two.
  always_ff @(posedge clk_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      per_cnt       <= '0;
      first_seen    <= 1'b0;
      period_cycles <= '0;
      period_valid  <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (en && (per_cnt != PER_MAX)) per_cnt <= per_cnt + 1'b1;
      if (state != MEASURE) begin
        first_seen <= 1'b0;
      end else if (meas_edge) begin
        per_cnt    <= PER_W'(1);
        first_seen <= 1'b1;
        if (first_seen) begin
          period_cycles <= per_cnt;
          period_valid  <= 1'b1;
        end
      end
    end
  end
`else
  assign period_cycles = '0;
  assign period_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_freq_meter.sv
module tb_freq_meter;

  logic       clk_50MHz;
  logic       reset_n;
  logic       en_a, en_b;
  logic       sig_a, sig_b;

  logic [7:0]  freq_count_a;
  logic        freq_valid_a, overflow_a, no_signal_a;
  logic [25:0] period_cycles_a;
  logic        period_valid_a;

  logic [2:0]  freq_count_b;
  logic        freq_valid_b, overflow_b, no_signal_b;
  logic [25:0] period_cycles_b;
  logic        period_valid_b;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int hi_a = 0, lo_a = 0, ph_a = 0;
  int hi_b = 0, lo_b = 0, ph_b = 0;
  logic per_bad = 1'b0;

  freq_meter #(.GATE_CYCLES(100), .CNT_W(8), .PER_W(26)) dut_a (
    .clk_50MHz(clk_50MHz), .reset_n(reset_n), .en(en_a), .sig_in(sig_a),
    .freq_count(freq_count_a), .freq_valid(freq_valid_a),
    .overflow(overflow_a), .no_signal(no_signal_a),
    .period_cycles(period_cycles_a), .period_valid(period_valid_a)
  );

  freq_meter #(.GATE_CYCLES(100), .CNT_W(3), .PER_W(26)) dut_b (
    .clk_50MHz(clk_50MHz), .reset_n(reset_n), .en(en_b), .sig_in(sig_b),
    .freq_count(freq_count_b), .freq_valid(freq_valid_b),
    .overflow(overflow_b), .no_signal(no_signal_b),
    .period_cycles(period_cycles_b), .period_valid(period_valid_b)
  );

  initial begin
    clk_50MHz = 1'b0;
    forever #10 clk_50MHz = ~clk_50MHz;
  end

  always @(posedge clk_50MHz) cyc = cyc + 1;

  // Square-wave generators: hi/lo are phase lengths in clocks; hi == 0 holds low.
  always @(negedge clk_50MHz) begin
    if (hi_a == 0) begin
      sig_a = 1'b0;
      ph_a  = 0;
    end else begin
      ph_a = ph_a + 1;
      if (ph_a >= (sig_a ? hi_a : lo_a)) begin
        sig_a = ~sig_a;
        ph_a  = 0;
      end
    end
    if (hi_b == 0) begin
      sig_b = 1'b0;
      ph_b  = 0;
    end else begin
      ph_b = ph_b + 1;
      if (ph_b >= (sig_b ? hi_b : lo_b)) begin
        sig_b = ~sig_b;
        ph_b  = 0;
      end
    end
    if (period_valid_a !== 1'b0 || period_cycles_a !== 26'd0) per_bad = 1'b1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d required=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_50MHz);
  endtask

  task automatic wait_strobe(input int which, input int budget, input string tag, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_50MHz);
      if ((which == 0) ? freq_valid_a : freq_valid_b) begin
        at = cyc;
        break;
      end
    end
    check(tag, 64'(at != -1), 64'd1);
  endtask

  task automatic count_strobes(input int n, output int k);
    k = 0;
    repeat (n) begin
      @(negedge clk_50MHz);
      if (freq_valid_a) k++;
    end
  endtask

  int c0, t1, t2, t3, t4, t5, t6, t7, t8, t9, t10, t11, k;

  initial begin
    reset_n = 1'b1;
    en_a    = 1'b0;
    en_b    = 1'b0;
    sig_a   = 1'b0;
    sig_b   = 1'b0;
    #3;
    reset_n = 1'b0;
    tick(3);

    // reset state
    check("rst_count",  64'(freq_count_a),    64'd0);
    check("rst_valid",  64'(freq_valid_a),    64'd0);
    check("rst_ovf",    64'(overflow_a),      64'd0);
    check("rst_nosig",  64'(no_signal_a),     64'd0);
    check("rst_period", 64'(period_cycles_a), 64'd0);
    check("rst_pvalid", 64'(period_valid_a),  64'd0);

    // test 1 / test 3 setup: period 10 on a, period 4 on b
    reset_n = 1'b1;
    hi_a = 5; lo_a = 5;
    hi_b = 2; lo_b = 2;
    tick(2);
    en_a = 1'b1;
    en_b = 1'b1;
    c0 = cyc;
    wait_strobe(0, 300, "t1_timeout", t1);
    check("t1_latency", 64'(t1 - c0), 64'd101);
    check("t1_count",   64'(freq_count_a), 64'd10);
    check("t1_ovf",     64'(overflow_a),   64'd0);
    check("t1_nosig",   64'(no_signal_a),  64'd0);
    check("b_sat_valid", 64'(freq_valid_b), 64'd1);
    check("b_sat_count", 64'(freq_count_b), 64'd7);
    check("b_sat_ovf",   64'(overflow_b),   64'd1);
    hi_b = 12; lo_b = 13;
    tick(1);
    check("t1_one_cycle", 64'(freq_valid_a), 64'd0);
    wait_strobe(0, 150, "t2_timeout", t2);
    check("t2_gap",   64'(t2 - t1), 64'd100);
    check("t2_count", 64'(freq_count_a), 64'd10);
    wait_strobe(0, 150, "t3_timeout", t3);
    check("t3_gap",   64'(t3 - t2), 64'd100);
    check("t3_count", 64'(freq_count_a), 64'd10);
    check("b_p25_valid", 64'(freq_valid_b), 64'd1);
    check("b_p25_count", 64'(freq_count_b), 64'd4);
    check("b_p25_ovf",   64'(overflow_b),   64'd0);
    en_b = 1'b0;

    // test 2: no signal for two full windows, then restart
    hi_a = 0;
    wait_strobe(0, 150, "t4_timeout", t4);
    wait_strobe(0, 150, "t5_timeout", t5);
    check("nosig1_count", 64'(freq_count_a), 64'd0);
    check("nosig1_flag",  64'(no_signal_a),  64'd1);
    wait_strobe(0, 150, "t6_timeout", t6);
    check("nosig2_count", 64'(freq_count_a), 64'd0);
    check("nosig2_flag",  64'(no_signal_a),  64'd1);
    hi_a = 5; lo_a = 5;
    wait_strobe(0, 150, "t7_timeout", t7);
    wait_strobe(0, 150, "t8_timeout", t8);
    check("restart_count", 64'(freq_count_a), 64'd10);
    check("restart_nosig", 64'(no_signal_a),  64'd0);

    // test 4: drop en at gate count 50
    tick(50);
    en_a = 1'b0;
    count_strobes(150, k);
    check("dis_no_strobe", 64'(k), 64'd0);
    check("dis_count",     64'(freq_count_a), 64'd10);
    check("dis_ovf",       64'(overflow_a),   64'd0);
    check("dis_nosig",     64'(no_signal_a),  64'd0);
    en_a = 1'b1;
    c0 = cyc;
    wait_strobe(0, 300, "t9_timeout", t9);
    check("reen_latency", 64'(t9 - c0), 64'd101);
    check("reen_count",   64'(freq_count_a), 64'd10);

    // test 5: reset mid-window
    tick(30);
    reset_n = 1'b0;
    #1;
    check("mid_rst_count", 64'(freq_count_a), 64'd0);
    check("mid_rst_valid", 64'(freq_valid_a), 64'd0);
    check("mid_rst_ovf",   64'(overflow_a),   64'd0);
    check("mid_rst_nosig", 64'(no_signal_a),  64'd0);
    count_strobes(3, k);
    check("mid_rst_no_strobe", 64'(k), 64'd0);
    reset_n = 1'b1;
    c0 = cyc;
    wait_strobe(0, 300, "t10_timeout", t10);
    check("post_rst_latency", 64'(t10 - c0), 64'd101);
    wait_strobe(0, 150, "t11_timeout", t11);
    check("post_rst_gap",   64'(t11 - t10), 64'd100);
    check("post_rst_count", 64'(freq_count_a), 64'd10);

    // test 6: period measurement with sig_in period 37
    hi_a = 18; lo_a = 19;
    tick(60);
    en_a = 1'b0;
    tick(2);
    en_a = 1'b1;
    c0 = cyc;
`ifdef FREQ_METER_PERIOD_EN
    begin
      int p1, p2;
      p1 = -1;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk_50MHz);
        if (period_valid_a) begin p1 = cyc; break; end
      end
      check("per1_seen",     64'(p1 != -1), 64'd1);
      check("per1_not_first", 64'(p1 - c0 >= 39), 64'd1);
      check("per1_value",    64'(period_cycles_a), 64'd37);
      p2 = -1;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk_50MHz);
        if (period_valid_a) begin p2 = cyc; break; end
      end
      check("per2_seen",  64'(p2 != -1), 64'd1);
      check("per2_gap",   64'(p2 - p1), 64'd37);
      check("per2_value", 64'(period_cycles_a), 64'd37);
    end
`else
    tick(150);
    check("per_tied_zero", 64'(per_bad), 64'd0);
    check("per_cycles_zero", 64'(period_cycles_a), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
